row_feed_sequencer: RTL and testbench

Trellis-step sequencer that sits directly upstream of the per-state row calculation array in the SISO decoder. For each step it reads the previous state-metric row and the LLRs, forms two saturated branch metrics, and presents row, branch, norm, address and valid to the row calculators. It then stalls until the new row has been written back, and supports forward (alpha) and backward (beta) recursion.

---
 rtl/siso_pkg.sv | 33 +++
 rtl/branch_metric_calc.sv | 29 ++
 rtl/row_feed_sequencer.sv | 174 +++++++++++++++++
 tb/tb_row_feed_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared SISO decoder definitions: default widths, sequencer FSM encoding,
// recursion direction constants and the branch-metric saturation helper.
package siso_pkg;

  localparam int DEF_DWIDTH     = 16;
  localparam int DEF_NUM_STATES = 8;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_ISSUE,
    ST_WAIT_WB,
    ST_DONE
  } state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The caller keeps the low w bits of the result.
  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v,
                                                input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/branch_metric_calc.sv
// Combinational branch metrics: g0/g1 = (sys + apr +/- par) >>> 1, saturated
// back to DWIDTH. Per-state sign selection happens in the row calculators.
module branch_metric_calc
  import siso_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic signed [DWIDTH-1:0] sys,
  input  logic signed [DWIDTH-1:0] apr,
  input  logic signed [DWIDTH-1:0] par,
  output logic signed [DWIDTH-1:0] gamma0,
  output logic signed [DWIDTH-1:0] gamma1
);

  // Two guard bits cover the worst case |sys + apr + par| = 3 * 2^(DWIDTH-1).
  localparam int SW = DWIDTH + 2;

  logic signed [SW-1:0] s;
  logic signed [SW-1:0] t0;
  logic signed [SW-1:0] t1;

  assign s  = SW'(sys) + SW'(apr);
  assign t0 = s + SW'(par);
  assign t1 = s - SW'(par);

  assign gamma0 = DWIDTH'(sat_dw(32'(t0 >>> 1), DWIDTH));
  assign gamma1 = DWIDTH'(sat_dw(32'(t1 >>> 1), DWIDTH));

endmodule

// File: rtl/row_feed_sequencer.sv
// Trellis-step sequencer feeding the per-state row calculators: fetches the
// previous metric row and LLRs, issues one step, then waits for write-back.
module row_feed_sequencer
  import siso_pkg::*;
#(
  parameter  int DWIDTH     = DEF_DWIDTH,
  parameter  int DEPTH_RAM  = 3072,
  parameter  int NUM_STATES = DEF_NUM_STATES,
  parameter  int RD_LAT     = 1,
  localparam int AW         = $clog2(DEPTH_RAM)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         i_start,
  input  logic                         i_dir,
  input  logic [AW:0]                  i_len,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [AW-1:0]                o_llr_raddr,
  output logic [AW-1:0]                o_sm_raddr,
  output logic                         o_ren,
  input  logic [DWIDTH-1:0]            i_sys,
  input  logic [DWIDTH-1:0]            i_apr,
  input  logic [DWIDTH-1:0]            i_par,
  input  logic [NUM_STATES*DWIDTH-1:0] i_sm_row,
  output logic [NUM_STATES*DWIDTH-1:0] o_row,
  output logic [DWIDTH-1:0]            o_norm,
  output logic [DWIDTH-1:0]            o_gamma0,
  output logic [DWIDTH-1:0]            o_gamma1,
  output logic [AW-1:0]                o_addr,
  output logic                         o_valid,
  input  logic                         i_wb_valid
);

  localparam int LEN_W = AW + 1;

  state_t          state;
  logic            dir_q;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]   k_q;
  logic [1:0]      lat_cnt;

  logic [AW-1:0]   start_k;
  logic [AW-1:0]   start_src;
  logic [AW-1:0]   step_k;
  logic            is_last;
  logic [DWIDTH-1:0] gamma0;
  logic [DWIDTH-1:0] gamma1;

  branch_metric_calc #(
    .DWIDTH (DWIDTH)
  ) u_bm (
    .sys    (i_sys),
    .apr    (i_apr),
    .par    (i_par),
    .gamma0 (gamma0),
    .gamma1 (gamma1)
  );

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    start_k   = AW'(1);
    start_src = '0;
    if (i_dir == DIR_BWD) begin
      start_k   = AW'(i_len - LEN_W'(2));
      start_src = AW'(i_len - LEN_W'(1));
    end
  end

  // The source row of step k is k-1 (forward) or k+1 (backward), so after a
  // step the next read address is simply the old k.
  assign step_k  = (dir_q == DIR_FWD) ? k_q + AW'(1) : k_q - AW'(1);
  assign is_last = (dir_q == DIR_FWD) ? ({1'b0, k_q} == len_q - LEN_W'(1))
                                      : (k_q == '0);

  // NOTE: only control and output registers exist here (no memories), and
  // all of them reset so an abort leaves every output at zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      dir_q       <= 1'b0;
      len_q       <= '0;
      k_q         <= '0;
      lat_cnt     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ren       <= 1'b0;
      o_llr_raddr <= '0;
      o_sm_raddr  <= '0;
      o_row       <= '0;
      o_norm      <= '0;
      o_gamma0    <= '0;
      o_gamma1    <= '0;
      o_addr      <= '0;
      o_valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobes default low
      // here and are raised only by the transition that needs them.
      o_done  <= 1'b0;
      o_ren   <= 1'b0;
      o_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            dir_q <= i_dir;
            len_q <= i_len;
            if (i_len < LEN_W'(2)) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              k_q         <= start_k;
              o_sm_raddr  <= start_src;
              o_llr_raddr <= start_src;
              o_ren       <= 1'b1;
              o_busy      <= 1'b1;
              state       <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (RD_LAT == 1) begin
            state <= ST_ISSUE;
          end else begin
            lat_cnt <= 2'(RD_LAT - 2);
            state   <= ST_WAIT_RD;
          end
        end

        ST_WAIT_RD: begin
          if (lat_cnt == '0) state <= ST_ISSUE;
          else               lat_cnt <= lat_cnt - 2'd1;
        end

        ST_ISSUE: begin
          o_row    <= i_sm_row;
          o_norm   <= i_sm_row[DWIDTH-1:0];
          o_gamma0 <= gamma0;
          o_gamma1 <= gamma1;
          o_addr   <= k_q;
          o_valid  <= 1'b1;
          state    <= ST_WAIT_WB;
        end

        ST_WAIT_WB: begin
          if (i_wb_valid) begin
            if (is_last) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              k_q         <= step_k;
              o_sm_raddr  <= k_q;
              o_llr_raddr <= k_q;
              o_ren       <= 1'b1;
              state       <= ST_READ;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_feed_sequencer.sv
// Directed self-checking bench for row_feed_sequencer with a 1-cycle RAM model.
module tb_row_feed_sequencer;
  import siso_pkg::*;

  localparam int DW    = 16;
  localparam int NS    = 8;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              i_start = 1'b0;
  logic              i_dir = 1'b0;
  logic [AW:0]       i_len = '0;
  logic              o_busy, o_done, o_ren, o_valid;
  logic [AW-1:0]     o_llr_raddr, o_sm_raddr, o_addr;
  logic [DW-1:0]     i_sys = '0, i_apr = '0, i_par = '0;
  logic [NS*DW-1:0]  i_sm_row;
  logic [NS*DW-1:0]  o_row;
  logic [DW-1:0]     o_norm, o_gamma0, o_gamma1;
  logic              i_wb_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int ren_cnt = 0;

  logic [AW-1:0] rd_sm = '0;
  logic          neg_row = 1'b0;

  row_feed_sequencer #(
    .DWIDTH (DW), .DEPTH_RAM (DEPTH), .NUM_STATES (NS), .RD_LAT (1)
  ) dut (
    .aclk (aclk), .aresetn (aresetn), .i_start (i_start), .i_dir (i_dir),
    .i_len (i_len), .o_busy (o_busy), .o_done (o_done),
    .o_llr_raddr (o_llr_raddr), .o_sm_raddr (o_sm_raddr), .o_ren (o_ren),
    .i_sys (i_sys), .i_apr (i_apr), .i_par (i_par), .i_sm_row (i_sm_row),
    .o_row (o_row), .o_norm (o_norm), .o_gamma0 (o_gamma0),
    .o_gamma1 (o_gamma1), .o_addr (o_addr), .o_valid (o_valid),
    .i_wb_valid (i_wb_valid)
  );

  always #5 aclk = ~aclk;

  // State-metric RAM content: row a, state s holds a*16+s; state 0 may be forced to -7.
  function automatic logic [NS*DW-1:0] exp_row(input logic [AW-1:0] a, input logic neg);
    logic [NS*DW-1:0] r;
    for (int s = 0; s < NS; s++) r[s*DW +: DW] = DW'(int'(a) * 16 + s);
    if (neg) r[DW-1:0] = 16'hFFF9;
    return r;
  endfunction

  function automatic logic [DW-1:0] w16(input int v);
    logic [31:0] t;
    t = v;
    return t[DW-1:0];
  endfunction

  always @(posedge aclk) if (o_ren) rd_sm <= o_sm_raddr;
  always_comb i_sm_row = exp_row(rd_sm, neg_row);

  always @(posedge aclk) begin
    if (o_valid) valid_cnt++;
    if (o_done)  done_cnt++;
    if (o_ren)   ren_cnt++;
  end

  task automatic check(input string tag, input logic [NS*DW-1:0] obs, input logic [NS*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic start(input logic dir, input int len);
    i_dir   = dir;
    i_len   = (AW+1)'(len);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wb_pulse();
    i_wb_valid = 1'b1;
    tick();
    i_wb_valid = 1'b0;
  endtask

  // Entered at the negedge where o_ren should be high; leaves after the
  // write-back pulse (or at the o_valid negedge when wb_delay < 0).
  task automatic run_step(input int src, input int addr, input int wb_delay);
    logic [NS*DW-1:0] row;
    row = exp_row(AW'(src), neg_row);
    check("ren", o_ren, 1);
    check("sm_raddr", o_sm_raddr, src);
    check("llr_raddr", o_llr_raddr, src);
    tick();
    check("valid_early", o_valid, 0);
    tick();
    check("valid", o_valid, 1);
    check("addr", o_addr, addr);
    check("row", o_row, row);
    check("norm", o_norm, row[DW-1:0]);
    if (wb_delay >= 0) begin
      repeat (wb_delay) tick();
      wb_pulse();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", o_done, 1);
  endtask

  initial begin
    int v0, d0, r0, bad;
    logic [NS*DW-1:0] hold_row;
    logic [AW-1:0]    hold_addr;

    // Reset state
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_ren", o_ren, 0);
    check("rst_valid", o_valid, 0);
    check("rst_row", o_row, 0);
    check("rst_addr", o_addr, 0);
    aresetn = 1'b1;
    tick();

    // 1. Forward, len=4
    v0 = valid_cnt; d0 = done_cnt;
    start(DIR_FWD, 4);
    check("t1_busy", o_busy, 1);
    run_step(0, 1, 3);
    run_step(1, 2, 3);
    run_step(2, 3, 3);
    check("t1_done", o_done, 1);
    check("t1_busy_done", o_busy, 0);
    tick();
    check("t1_done_pulse", o_done, 0);
    check("t1_valid_cnt", valid_cnt - v0, 3);
    check("t1_done_cnt", done_cnt - d0, 1);

    // 2. Backward, len=4
    v0 = valid_cnt;
    start(DIR_BWD, 4);
    run_step(3, 2, 3);
    run_step(2, 1, 1);
    run_step(1, 0, 0);
    check("t2_done", o_done, 1);
    tick();
    check("t2_valid_cnt", valid_cnt - v0, 3);

    // 3. Saturation and norm
    i_sys = w16(32767); i_apr = w16(32767); i_par = w16(32767);
    start(DIR_FWD, 2);
    run_step(0, 1, -1);
    check("sat_pos_g0", o_gamma0, w16(32767));
    check("sat_pos_g1", o_gamma1, w16(16383));
    wb_pulse();
    check("t3a_done", o_done, 1);
    tick();
    i_sys = w16(-32768); i_apr = w16(-32768); i_par = w16(-32768);
    start(DIR_FWD, 2);
    run_step(0, 1, -1);
    check("sat_neg_g0", o_gamma0, w16(-32768));
    check("sat_neg_g1", o_gamma1, w16(-16384));
    wb_pulse();
    tick();
    i_sys = w16(10); i_apr = w16(-4); i_par = w16(3);
    neg_row = 1'b1;
    start(DIR_FWD, 2);
    run_step(0, 1, -1);
    check("mix_g0", o_gamma0, w16(4));
    check("mix_g1", o_gamma1, w16(1));
    check("norm_neg7", o_norm, w16(-7));
    wb_pulse();
    tick();
    neg_row = 1'b0;

    // 4. Degenerate lengths
    v0 = valid_cnt; r0 = ren_cnt;
    start(DIR_FWD, 1);
    check("len1_done", o_done, 1);
    check("len1_busy", o_busy, 0);
    tick();
    check("len1_done_pulse", o_done, 0);
    start(DIR_BWD, 0);
    check("len0_done", o_done, 1);
    tick();
    tick();
    check("len01_no_valid", valid_cnt - v0, 0);
    check("len01_no_ren", ren_cnt - r0, 0);

    // 5. Hold in WAIT_WB, ignored start, stray write-back in IDLE
    start(DIR_FWD, 3);
    run_step(0, 1, -1);
    hold_row = o_row; hold_addr = o_addr;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin i_dir = DIR_BWD; i_len = 13'd2; i_start = 1'b1; end
      if (i == 11) i_start = 1'b0;
      tick();
      if (o_row !== hold_row || o_addr !== hold_addr || o_valid || o_ren ||
          !o_busy || dut.state !== ST_WAIT_WB) bad++;
    end
    check("hold_stable", bad, 0);
    wb_pulse();
    run_step(1, 2, 2);
    check("t5_done", o_done, 1);
    tick();
    wb_pulse();
    check("stray_wb_state", dut.state, ST_IDLE);
    check("stray_wb_ren", o_ren, 0);
    tick();
    check("stray_wb_valid", o_valid, 0);
    check("stray_wb_busy", o_busy, 0);

    // 6. Reset during WAIT_WB of step 2, then a clean restart
    start(DIR_FWD, 4);
    run_step(0, 1, 3);
    run_step(1, 2, -1);
    d0 = done_cnt;
    #2 aresetn = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_valid, 0);
    check("abort_addr", o_addr, 0);
    check("abort_row", o_row, 0);
    check("abort_raddr", o_sm_raddr, 0);
    check("abort_norm", o_norm, 0);
    tick();
    aresetn = 1'b1;
    tick();
    tick();
    check("abort_no_done", done_cnt - d0, 0);
    start(DIR_FWD, 2);
    run_step(0, 1, 2);
    wait_done();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
